// File: rtl/sample_voice_sched_if.sv
// Bus bundle for sample_voice_sched: trigger/config inputs, shared ROM port, audio outputs.
// The loop port exists only when SAMPLE_VOICE_LOOP_EN is defined.
interface sample_voice_sched_if #(
    parameter int unsigned VOICES = 2,
    parameter int unsigned AW     = 14
);
    logic [VOICES-1:0]    trig;
    logic [VOICES*AW-1:0] start_addr;
    logic [VOICES*AW-1:0] length;
`ifdef SAMPLE_VOICE_LOOP_EN
    logic [VOICES-1:0]    loop;
`endif
    logic [AW-1:0]        rom_a;
    logic                 rom_rd;
    logic [7:0]           rom_d;
    logic [VOICES*8-1:0]  voice_out;
    logic [15:0]          mix_out;
    logic [VOICES-1:0]    playing;
    logic                 sample_tick;

`ifdef SAMPLE_VOICE_LOOP_EN
    modport master (output trig, start_addr, length, loop, rom_d,
                    input  rom_a, rom_rd, voice_out, mix_out, playing, sample_tick);
    modport slave  (input  trig, start_addr, length, loop, rom_d,
                    output rom_a, rom_rd, voice_out, mix_out, playing, sample_tick);
`else
    modport master (output trig, start_addr, length, rom_d,
                    input  rom_a, rom_rd, voice_out, mix_out, playing, sample_tick);
    modport slave  (input  trig, start_addr, length, rom_d,
                    output rom_a, rom_rd, voice_out, mix_out, playing, sample_tick);
`endif
endinterface

// File: rtl/sample_voice_sched.sv
// Round-robin sample playback scheduler: VOICES voices share one ROM read port, one fetch per voice per tick.
// Optional macro SAMPLE_VOICE_LOOP_EN adds per-voice looping through bus.loop.
module sample_voice_sched #(
    parameter int unsigned VOICES  = 2,
    parameter int unsigned AW      = 14,
    parameter int unsigned DIV     = 2177,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    sample_voice_sched_if.slave bus
);
    localparam int unsigned VW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int unsigned PW = $clog2(DIV);
    localparam int unsigned LW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam int unsigned MW = 8 + $clog2(VOICES);
    localparam logic [15:0] MIX_IDLE = 16'((VOICES * 128) << (16 - MW));

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, MIX} state_t;

    state_t            state_q, state_d;
    logic [VW-1:0]     v_q, v_d;
    logic [LW-1:0]     wait_q, wait_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic              tick_q;
    logic [VOICES-1:0] pending_q, pending_d, playing_q, playing_d, svc;
    logic [AW-1:0]     ptr_q [VOICES], ptr_d [VOICES];
    logic [AW-1:0]     rem_q [VOICES], rem_d [VOICES];
    logic [AW-1:0]     start_lat_q [VOICES], start_lat_d [VOICES];
    logic [AW-1:0]     len_lat_q [VOICES], len_lat_d [VOICES];
    logic [7:0]        voice_q [VOICES], voice_d [VOICES];
    logic [15:0]       mix_q, mix_d;
    logic [AW-1:0]     rom_a_q, rom_a_d;
    logic              rom_rd_q, rom_rd_d;
    logic [MW-1:0]     sum;
    logic              advance, loop_now;

    // Free-running sample prescaler; tick is high while the count sits at DIV-1.
    assign pre_d = (pre_q == PW'(DIV - 1)) ? '0 : pre_q + PW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= (pre_d == PW'(DIV - 1));
        end
    end

    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        wait_d      = wait_q;
        playing_d   = playing_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        start_lat_d = start_lat_q;
        len_lat_d   = len_lat_q;
        voice_d     = voice_q;
        mix_d       = mix_q;
        rom_a_d     = rom_a_q;
        rom_rd_d    = 1'b0;
        svc         = '0;
        advance     = 1'b0;
        sum         = '0;
`ifdef SAMPLE_VOICE_LOOP_EN
        loop_now    = bus.loop[v_q];
`else
        loop_now    = 1'b0;
`endif
        for (int i = 0; i < VOICES; i++) begin
            sum = sum + MW'(voice_q[i]);
        end

        case (state_q)
            IDLE: begin
                for (int i = 0; i < VOICES; i++) begin
                    if (pending_q[i]) begin
                        svc[i] = 1'b1;
                        if (bus.length[i*AW +: AW] != '0) begin
                            ptr_d[i]       = bus.start_addr[i*AW +: AW];
                            rem_d[i]       = bus.length[i*AW +: AW];
                            start_lat_d[i] = bus.start_addr[i*AW +: AW];
                            len_lat_d[i]   = bus.length[i*AW +: AW];
                            playing_d[i]   = 1'b1;
                        end
                    end
                end
                if (tick_q) begin
                    state_d = ISSUE;
                    v_d     = '0;
                end
            end
            ISSUE: begin
                if (!playing_q[v_q]) begin
                    voice_d[v_q] = 8'h80;
                    advance      = 1'b1;
                end else if (rem_q[v_q] == '0 && !loop_now) begin
                    playing_d[v_q] = 1'b0;
                    voice_d[v_q]   = 8'h80;
                    advance        = 1'b1;
                end else begin
                    // An exhausted looping voice restarts from its latched copy in this same visit.
                    if (rem_q[v_q] == '0) begin
                        ptr_d[v_q] = start_lat_q[v_q];
                        rem_d[v_q] = len_lat_q[v_q];
                        rom_a_d    = start_lat_q[v_q];
                    end else begin
                        rom_a_d    = ptr_q[v_q];
                    end
                    rom_rd_d = 1'b1;
                    wait_d   = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (wait_q == LW'(ROM_LAT - 1)) state_d = CAPT;
                else                            wait_d  = wait_q + LW'(1);
            end
            CAPT: begin
                voice_d[v_q] = bus.rom_d;
                ptr_d[v_q]   = ptr_q[v_q] + AW'(1);
                rem_d[v_q]   = rem_q[v_q] - AW'(1);
                advance      = 1'b1;
            end
            MIX: begin
                mix_d   = 16'(sum) << (16 - MW);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (v_q == VW'(VOICES - 1)) begin
                state_d = MIX;
            end else begin
                v_d     = v_q + VW'(1);
                state_d = ISSUE;
            end
        end

        // A pulse landing in the service cycle stays pending for the next pass.
        pending_d = (pending_q & ~svc) | bus.trig;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            v_q       <= '0;
            wait_q    <= '0;
            pending_q <= '0;
            playing_q <= '0;
            mix_q     <= MIX_IDLE;
            rom_a_q   <= '0;
            rom_rd_q  <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                ptr_q[i]       <= '0;
                rem_q[i]       <= '0;
                start_lat_q[i] <= '0;
                len_lat_q[i]   <= '0;
                voice_q[i]     <= 8'h80;
            end
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            wait_q      <= wait_d;
            pending_q   <= pending_d;
            playing_q   <= playing_d;
            mix_q       <= mix_d;
            rom_a_q     <= rom_a_d;
            rom_rd_q    <= rom_rd_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            start_lat_q <= start_lat_d;
            len_lat_q   <= len_lat_d;
            voice_q     <= voice_d;
        end
    end

    assign bus.rom_a       = rom_a_q;
    assign bus.rom_rd      = rom_rd_q;
    assign bus.mix_out     = mix_q;
    assign bus.playing     = playing_q;
    assign bus.sample_tick = tick_q;

    for (genvar g = 0; g < VOICES; g++) begin : g_vout
        assign bus.voice_out[g*8 +: 8] = voice_q[g];
    end
endmodule

// File: tb/tb_sample_voice_sched.sv
// Directed bench for sample_voice_sched with a registered 1-cycle ROM model (ROM[a]=a[7:0], two overrides).
// Define SAMPLE_VOICE_LOOP_EN on both RTL and bench to exercise looping.
module tb_sample_voice_sched;
    localparam int unsigned VOICES  = 2;
    localparam int unsigned AW      = 14;
    localparam int unsigned DIV     = 50;
    localparam int unsigned ROM_LAT = 1;

    logic clk = 1'b0;
    logic reset;

    sample_voice_sched_if #(.VOICES(VOICES), .AW(AW)) bus ();

    sample_voice_sched #(.VOICES(VOICES), .AW(AW), .DIV(DIV), .ROM_LAT(ROM_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_val(input logic [AW-1:0] a);
        if (a == 14'h0010) return 8'hFF;
        if (a == 14'h0020) return 8'h01;
        return a[7:0];
    endfunction

    always @(posedge clk) bus.rom_d <= rom_val(bus.rom_a);

    int cyc = 0;
    int rd_cnt = 0;
    int n_ticks = 0;
    int tick_cyc = 0;
    int prev_tick_cyc = 0;
    logic [AW-1:0] addr_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rom_rd) begin
            rd_cnt <= rd_cnt + 1;
            addr_q.push_back(bus.rom_a);
        end
        if (bus.sample_tick) begin
            prev_tick_cyc <= tick_cyc;
            tick_cyc      <= cyc;
            n_ticks       <= n_ticks + 1;
        end
    end

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qa(input int i);
        if (i < addr_q.size()) return 32'(addr_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic set_voice(input int v, input logic [AW-1:0] sa, input logic [AW-1:0] len);
        bus.start_addr[v*AW +: AW] = sa;
        bus.length[v*AW +: AW]     = len;
    endtask

    task automatic pulse(input logic [VOICES-1:0] m);
        bus.trig = m;
        @(posedge clk); #1;
        bus.trig = '0;
    endtask

    task automatic settle();
        repeat (12) @(posedge clk);
        #1;
    endtask

    // Returns #1 into the cycle where sample_tick is high.
    task automatic wait_tick_edge();
        bit found = 1'b0;
        for (int i = 0; i < 2 * DIV && !found; i++) begin
            @(posedge clk); #1;
            if (bus.sample_tick) found = 1'b1;
        end
        if (!found) check("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_tick();
        wait_tick_edge();
        settle();
    endtask

    logic [7:0]    wrap_d [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [AW-1:0] wrap_a [4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        bit found;
        reset          = 1'b1;
        bus.trig       = '0;
        bus.start_addr = '0;
        bus.length     = '0;
`ifdef SAMPLE_VOICE_LOOP_EN
        bus.loop       = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_playing", 32'(bus.playing), 32'd0);
        check("rst_vout", 32'(bus.voice_out), 32'h8080);
        check("rst_mix", 32'(bus.mix_out), 32'h8000);
        check("rst_rd", 32'(bus.rom_rd), 32'd0);
        check("rst_a", 32'(bus.rom_a), 32'd0);
        check("rst_tick", 32'(bus.sample_tick), 32'd0);
        reset = 1'b0;

        // idle for three tick periods
        base = n_ticks;
        repeat (3 * DIV) @(posedge clk);
        #1;
        check("idle_ticks", 32'(n_ticks - base), 32'd3);
        check("idle_period", 32'(tick_cyc - prev_tick_cyc), 32'(DIV));
        check("idle_rd", 32'(rd_cnt), 32'd0);
        check("idle_playing", 32'(bus.playing), 32'd0);
        check("idle_vout", 32'(bus.voice_out), 32'h8080);
        check("idle_mix", 32'(bus.mix_out), 32'h8000);

        // one-shot voice 0, length 4
        wait_tick();
        set_voice(0, 14'h100, 14'd4);
        pulse(2'b01);
        base = rd_cnt;
        for (int k = 0; k < 4; k++) begin
            wait_tick();
            check($sformatf("os_v0_%0d", k), 32'(bus.voice_out[7:0]), 32'(k));
            check($sformatf("os_play_%0d", k), 32'(bus.playing), 32'd1);
            check($sformatf("os_mix_%0d", k), 32'(bus.mix_out), 32'((k + 128) << 7));
        end
        wait_tick();
        check("os_end_v0", 32'(bus.voice_out[7:0]), 32'h80);
        check("os_end_play", 32'(bus.playing), 32'd0);
        check("os_end_mix", 32'(bus.mix_out), 32'h8000);
        check("os_rd_count", 32'(rd_cnt - base), 32'd4);
        check("os_a_hold", 32'(bus.rom_a), 32'h103);

        // both voices in the same cycle
        set_voice(0, 14'h010, 14'd1);
        set_voice(1, 14'h020, 14'd1);
        base = addr_q.size();
        pulse(2'b11);
        wait_tick();
        check("dual_nrd", 32'(addr_q.size() - base), 32'd2);
        check("dual_a0", qa(base), 32'h10);
        check("dual_a1", qa(base + 1), 32'h20);
        check("dual_vout", 32'(bus.voice_out), 32'h01FF);
        check("dual_mix", 32'(bus.mix_out), 32'h8000);
        check("dual_play", 32'(bus.playing), 32'd3);
        wait_tick();
        check("dual_end_play", 32'(bus.playing), 32'd0);
        check("dual_end_vout", 32'(bus.voice_out), 32'h8080);

        // retrigger mid-playback
        set_voice(0, 14'h100, 14'd8);
        pulse(2'b01);
        wait_tick();
        check("rt_s0", 32'(bus.voice_out[7:0]), 32'h00);
        wait_tick();
        check("rt_s1", 32'(bus.voice_out[7:0]), 32'h01);
        set_voice(0, 14'h140, 14'd8);
        pulse(2'b01);
        wait_tick();
        check("rt_restart", 32'(bus.voice_out[7:0]), 32'h40);
        check("rt_play", 32'(bus.playing), 32'd1);

        // trigger in the tick cycle: current scan keeps old ptr, restart on the next tick
        set_voice(0, 14'h1C0, 14'd8);
        wait_tick_edge();
        bus.trig = 2'b01;
        @(posedge clk); #1;
        bus.trig = '0;
        settle();
        check("co_old", 32'(bus.voice_out[7:0]), 32'h41);
        wait_tick();
        check("co_new", 32'(bus.voice_out[7:0]), 32'hC0);

        // trigger pending in the tick cycle: load applied, scan uses the new ptr
        set_voice(0, 14'h1E0, 14'd8);
        repeat (tick_cyc + int'(DIV) - 1 - cyc) @(posedge clk);
        #1;
        pulse(2'b01);
        settle();
        check("pl_first", 32'(bus.voice_out[7:0]), 32'hE0);
        wait_tick();
        check("pl_second", 32'(bus.voice_out[7:0]), 32'hE1);

        // length 0 triggers are discarded
        set_voice(0, 14'h000, 14'd0);
        set_voice(1, 14'h000, 14'd0);
        pulse(2'b11);
        wait_tick();
        check("len0_v0", 32'(bus.voice_out[7:0]), 32'hE2);
        check("len0_play", 32'(bus.playing), 32'd1);

        // reset while a fetch is in flight
        found = 1'b0;
        for (int i = 0; i < 2 * DIV && !found; i++) begin
            @(posedge clk); #1;
            if (bus.rom_rd) found = 1'b1;
        end
        if (!found) check("rd_timeout", 32'd0, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mr_playing", 32'(bus.playing), 32'd0);
        check("mr_vout", 32'(bus.voice_out), 32'h8080);
        check("mr_mix", 32'(bus.mix_out), 32'h8000);
        check("mr_rd", 32'(bus.rom_rd), 32'd0);
        check("mr_a", 32'(bus.rom_a), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mr_nocapt", 32'(bus.voice_out), 32'h8080);

        // address wrap at the top of the ROM
        wait_tick();
        set_voice(0, 14'h3FFE, 14'd4);
        base = addr_q.size();
        pulse(2'b01);
        for (int k = 0; k < 4; k++) begin
            wait_tick();
            check($sformatf("wr_d_%0d", k), 32'(bus.voice_out[7:0]), 32'(wrap_d[k]));
            check($sformatf("wr_a_%0d", k), qa(base + k), 32'(wrap_a[k]));
        end
        wait_tick();
        check("wr_end_play", 32'(bus.playing), 32'd0);

`ifdef SAMPLE_VOICE_LOOP_EN
        // looping voice, then loop dropped mid-pass
        bus.loop = 2'b01;
        set_voice(0, 14'h100, 14'd2);
        pulse(2'b01);
        for (int k = 0; k < 5; k++) begin
            wait_tick();
            check($sformatf("lp_d_%0d", k), 32'(bus.voice_out[7:0]), 32'(k % 2));
            check($sformatf("lp_play_%0d", k), 32'(bus.playing), 32'd1);
        end
        bus.loop = '0;
        wait_tick();
        check("lp_last", 32'(bus.voice_out[7:0]), 32'h01);
        check("lp_last_play", 32'(bus.playing), 32'd1);
        wait_tick();
        check("lp_stop", 32'(bus.voice_out[7:0]), 32'h80);
        check("lp_stop_play", 32'(bus.playing), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sample_voice_sched.md
Name: sample_voice_sched

Overview:
- Multi-voice sample playback scheduler for the sound subsystem.
- Shares one single-port sample ROM (dpram read port, registered output) among VOICES independent playback voices.
- On each sample tick it fetches one byte per active voice in round-robin, then produces per-voice samples and a left-aligned unsigned mix for AUDIO_L/R.
- Replaces per-voice private ROMs and wav_player prescalers.

Parameters:
- VOICES, 2: number of voices, legal 1..8.
- AW, 14: ROM address width.
- DIV, 2177: clk cycles per sample tick. Must satisfy DIV > VOICES*(ROM_LAT+2)+2.
- ROM_LAT, 1: ROM read latency in cycles, from rom_a valid to rom_d valid.

Ports:
- clk  in  1  system clock (clk_sys).
- reset  in  1  synchronous, active-high.
- trig  in  VOICES  one-cycle start/retrigger pulse; bit i is voice i.
- start_addr  in  VOICES*AW  voice i start address at [i*AW +: AW]; sampled on trigger.
- length  in  VOICES*AW  voice i sample count at [i*AW +: AW]; sampled on trigger.
- rom_a  out  AW  shared ROM address.
- rom_rd  out  1  high in the cycle rom_a is presented.
- rom_d  in  8  ROM data, valid ROM_LAT cycles after rom_rd.
- voice_out  out  VOICES*8  per-voice unsigned sample; 8'h80 = silence.
- mix_out  out  16  unsigned sum of voice_out, left-aligned.
- playing  out  VOICES  voice active flags (drive LEDs).
- sample_tick  out  1  one-cycle pulse per sample period.

Behaviour:
- Reset values:
  - prescaler 0, state IDLE, pending 0.
  - ptr and remaining of every voice 0.
  - playing 0, voice_out all 8'h80, rom_a 0, rom_rd 0, sample_tick 0.
  - mix_out = VOICES*8'h80, left-aligned (16'h8000 for VOICES=2).
  - Reset mid-scan aborts the scan; no capture occurs.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - sample_tick is high for the one cycle in which the count equals DIV-1.
  - Free-running regardless of state.
- Triggers:
  - trig[i] sets pending[i]. Pulses arriving in any state are never lost.
  - Multiple pulses before service collapse into one.
- FSM states: IDLE, ISSUE, WAIT, CAPT, MIX.
  - IDLE:
    - Each pending[i] with length_i != 0 loads ptr_i=start_addr_i, remaining_i=length_i, latched copies of both, and sets playing[i]=1.
    - A pending trigger with length 0 is discarded and playing[i] is unchanged.
    - pending bits serviced in IDLE are cleared.
    - A retrigger of a playing voice restarts it from start_addr.
    - On sample_tick: v=0, go ISSUE. A load and a tick in the same cycle: the load is applied, and the scan starts next cycle using the new ptr.
  - ISSUE, voice v:
    - If playing[v]=0: voice_out[v]=8'h80, then go to the next voice.
    - If remaining_v==0: playing[v]=0, voice_out[v]=8'h80, then go to the next voice.
    - Otherwise: rom_a=ptr_v, rom_rd=1 for one cycle, go WAIT.
  - WAIT: hold for ROM_LAT cycles, then go CAPT.
  - CAPT: voice_out[v]=rom_d, ptr_v=ptr_v+1 (wraps modulo 2^AW), remaining_v-=1. Then go to the next voice.
  - Next voice: v+1; after v=VOICES-1 go MIX.
  - MIX: mix_out = sum(voice_out), width 8+clog2(VOICES), shifted left to bit 15, low bits 0. Then go IDLE.
- Playback timing:
  - playing stays high for one tick period after the last sample is captured, so the final sample is audible for a full period.
  - A voice of length N produces exactly N samples.
- Latency:
  - First sample appears on the tick after the trigger is serviced.
  - mix_out updates once per tick, VOICES*(ROM_LAT+2)+1 cycles after the tick at most.
- Other rules:
  - rom_rd is never asserted outside ISSUE.
  - rom_a holds its last value when idle.
  - Voice priority within a scan is fixed, 0 first. Fairness is guaranteed because every voice is served once per tick.

Optional Feature:
- Macro: SAMPLE_VOICE_LOOP_EN.
- When defined:
  - Adds input port loop (VOICES bits).
  - In ISSUE, if remaining_v==0 and loop[v]=1, ptr_v and remaining_v reload from their latched copies and the fetch proceeds in the same visit. playing stays 1 and there is no silent gap.
  - loop is sampled in ISSUE, so it may change at any time.
- When undefined: the port is absent and every voice is one-shot as described above.

Test Plan:
- Reset, then idle for 3*DIV cycles -> playing=0, rom_rd never high, voice_out=80/80, mix_out=16'h8000, one sample_tick every DIV cycles.
- trig[0] with start=0x100, length=4, ROM[a]=a[7:0] -> voice_out[0] = 00,01,02,03 on four consecutive ticks. Then 80 and playing[0]=0 at the fifth tick. Exactly 4 rom_rd pulses.
- Both voices triggered in the same cycle (v0 start 0x10 holding 0xFF, v1 start 0x20 holding 0x01) -> per tick, rom_a=0x10 then 0x20. mix_out=(0xFF+0x01)<<7=16'h8000.
- Retrigger v0 mid-playback, and trig coincident with sample_tick -> ptr restarts at start_addr and the new first sample appears on the next tick. A length=0 trigger leaves playing unchanged.
- start=0x3FFE, length=4 -> addresses 3FFE, 3FFF, 0000, 0001. Reset asserted during WAIT -> all reset values next cycle and no capture.
- With SAMPLE_VOICE_LOOP_EN, loop[0]=1, length=2 -> samples A,B,A,B… with playing held at 1. Dropping loop -> stops after the current pass.
